// File: rtl/cpu_result_checker_if.sv
// Bus bundle for the result checker: run control, expected-table load port,
// the snooped register/memory write buses and the verdict outputs.
interface cpu_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 8,
  parameter int N_EXP  = 8,
  parameter int IDX_W  = $clog2(N_EXP),
  parameter int CNT_W  = 16
);
  logic              start;
  logic              stop;
  logic              exp_clr;
  logic              exp_we;
  logic [IDX_W-1:0]  exp_idx;
  logic              exp_kind;
  logic [MEM_AW-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic [IDX_W-1:0]  fail_idx;
  logic [DATA_W-1:0] fail_got;
  logic [IDX_W:0]    match_count;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, stop, exp_clr, exp_we, exp_idx, exp_kind, exp_addr, exp_data,
    output reg_we, reg_waddr, reg_wdata, mem_we, mem_addr, mem_wdata,
    input  busy, done, pass, fail_idx, fail_got, match_count, cycle_count
  );

  modport slave (
    input  start, stop, exp_clr, exp_we, exp_idx, exp_kind, exp_addr, exp_data,
    input  reg_we, reg_waddr, reg_wdata, mem_we, mem_addr, mem_wdata,
    output busy, done, pass, fail_idx, fail_got, match_count, cycle_count
  );
endinterface

// File: rtl/cpu_result_checker.sv
// Result checker for the single-cycle MIPS core: snoops register and memory
// write-back during a bounded run window, then walks the expected table one
// entry per cycle and reports pass / first failure / match count.

// One expected-table slot: holds its target and expected value, and captures
// the last write to that target while the run window is open.
module cpu_result_checker_entry #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_clr,
  input  logic              tbl_we,
  input  logic              tbl_kind,
  input  logic [MEM_AW-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              run_clr,
  input  logic              run_en,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_waddr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              mem_we,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              valid,
  output logic [DATA_W-1:0] expd,
  output logic              seen,
  output logic [DATA_W-1:0] got
);
  logic              kind;
  logic [MEM_AW-1:0] addr;
  logic              hit_reg, hit_mem;

  // $zero is hard-wired in the core, so writes to it never count
  assign hit_reg = !kind && reg_we && (|reg_waddr) && (reg_waddr == addr[REG_AW-1:0]);
  assign hit_mem =  kind && mem_we && (mem_addr == addr);

  // expected-table slot; clear wins over write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      kind  <= 1'b0;
      addr  <= '0;
      expd  <= '0;
    end else if (tbl_clr) begin
      valid <= 1'b0;
    end else if (tbl_we) begin
      valid <= 1'b1;
      kind  <= tbl_kind;
      addr  <= tbl_addr;
      expd  <= tbl_data;
    end
  end

  // snoop capture: last write in the window wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen <= 1'b0;
      got  <= '0;
    end else if (run_clr) begin
      seen <= 1'b0;
      got  <= '0;
    end else if (run_en && valid && (hit_reg || hit_mem)) begin
      seen <= 1'b1;
      got  <= hit_reg ? reg_wdata : mem_wdata;
    end
  end
endmodule

module cpu_result_checker #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MEM_AW  = 8,
  parameter int N_EXP   = 8,
  parameter int IDX_W   = $clog2(N_EXP),
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  cpu_result_checker_if.slave bus
);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0]    RUN_LAST = RW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EXP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t                         state;
  logic [RW-1:0]                  run_cnt;
  logic [IDX_W-1:0]               chk_idx;
  logic                           pass_cand;
  logic                           busy_q, done_q, pass_q;
  logic [IDX_W-1:0]               fail_idx_q;
  logic [DATA_W-1:0]              fail_got_q;
  logic [IDX_W:0]                 match_q;
  logic [CNT_W-1:0]               cyc_q;

  logic [N_EXP-1:0]               ent_valid, ent_seen;
  logic [N_EXP-1:0][DATA_W-1:0]   ent_exp, ent_got;

  logic cfg_ok, cfg_clr, cfg_we, start_acc, run_en;
  logic cur_valid, cur_hit, cur_fail;

  assign cfg_ok    = (state == S_IDLE) || (state == S_DONE);
  assign cfg_clr   = cfg_ok && bus.exp_clr;
  assign cfg_we    = cfg_ok && bus.exp_we && !bus.exp_clr;
  assign start_acc = cfg_ok && bus.start;
  assign run_en    = (state == S_RUN);

  for (genvar i = 0; i < N_EXP; i++) begin : g_ent
    cpu_result_checker_entry #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_AW(MEM_AW)
    ) u_ent (
      .clk       (clk),
      .reset     (reset),
      .tbl_clr   (cfg_clr),
      .tbl_we    (cfg_we && (bus.exp_idx == IDX_W'(i))),
      .tbl_kind  (bus.exp_kind),
      .tbl_addr  (bus.exp_addr),
      .tbl_data  (bus.exp_data),
      .run_clr   (start_acc),
      .run_en    (run_en),
      .reg_we    (bus.reg_we),
      .reg_waddr (bus.reg_waddr),
      .reg_wdata (bus.reg_wdata),
      .mem_we    (bus.mem_we),
      .mem_addr  (bus.mem_addr),
      .mem_wdata (bus.mem_wdata),
      .valid     (ent_valid[i]),
      .expd      (ent_exp[i]),
      .seen      (ent_seen[i]),
      .got       (ent_got[i])
    );
  end

  // entry currently under examination in CHECK
  assign cur_valid = ent_valid[chk_idx];
  assign cur_hit   = ent_seen[chk_idx] && (ent_got[chk_idx] == ent_exp[chk_idx]);
  assign cur_fail  = cur_valid && !cur_hit;

  // run-control FSM with registered verdict outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      run_cnt    <= '0;
      chk_idx    <= '0;
      pass_cand  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      match_q    <= '0;
      cyc_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            fail_got_q <= '0;
            match_q    <= '0;
            cyc_q      <= '0;
            run_cnt    <= '0;
            chk_idx    <= '0;
            pass_cand  <= 1'b1;
          end
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
          run_cnt <= run_cnt + 1'b1;
          // the stop cycle itself is counted and its writes captured
          if (bus.stop || run_cnt == RUN_LAST) state <= S_CHECK;
        end
        S_CHECK: begin
          if (cur_valid) begin
            if (cur_hit) begin
              match_q <= match_q + 1'b1;
            end else if (pass_cand) begin
              fail_idx_q <= chk_idx;
              fail_got_q <= ent_got[chk_idx];
              pass_cand  <= 1'b0;
            end
          end
          if (chk_idx == LAST_IDX) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= pass_cand && !cur_fail;
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_idx    = fail_idx_q;
  assign bus.fail_got    = fail_got_q;
  assign bus.match_count = match_q;
  assign bus.cycle_count = cyc_q;
endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench for cpu_result_checker: the driver computes each run's
// verdict from a write-history model and queues it; a monitor compares on done.
module tb_cpu_result_checker;
  localparam int DW = 32, RA = 5, MA = 8, N = 8, IW = 3, TO = 20, CW = 16;

  typedef struct {
    bit          pass;
    int          fidx;
    logic [31:0] fgot;
    int          mcnt;
    int          ccnt;
    longint      done_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     ncmp = 0, nfail = 0;
  exp_t   sb[$];

  // model of the expected table
  bit          m_valid[N];
  bit          m_kind[N];
  int          m_addr[N];
  logic [31:0] m_data[N];
  // per-RUN-cycle write schedule, index 1..TO
  bit          s_rwe[0:TO];
  int          s_rad[0:TO];
  logic [31:0] s_rdt[0:TO];
  bit          s_mwe[0:TO];
  int          s_mad[0:TO];
  logic [31:0] s_mdt[0:TO];

  cpu_result_checker_if #(.DATA_W(DW), .REG_AW(RA), .MEM_AW(MA), .N_EXP(N),
                          .IDX_W(IW), .CNT_W(CW)) ifc ();

  cpu_result_checker #(.DATA_W(DW), .REG_AW(RA), .MEM_AW(MA), .N_EXP(N),
                       .IDX_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst_n), .bus(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    ifc.start = 0; ifc.stop = 0; ifc.exp_clr = 0; ifc.exp_we = 0;
    ifc.exp_idx = '0; ifc.exp_kind = 0; ifc.exp_addr = '0; ifc.exp_data = '0;
    ifc.reg_we = 0; ifc.reg_waddr = '0; ifc.reg_wdata = '0;
    ifc.mem_we = 0; ifc.mem_addr = '0; ifc.mem_wdata = '0;
  endtask

  task automatic tbl_clr();
    @(negedge clk); ifc.exp_clr = 1;
    @(negedge clk); ifc.exp_clr = 0;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
  endtask

  task automatic tbl_wr(input int i, input bit k, input int a, input logic [31:0] d);
    @(negedge clk);
    ifc.exp_we = 1; ifc.exp_idx = IW'(i); ifc.exp_kind = k;
    ifc.exp_addr = MA'(a); ifc.exp_data = d;
    @(negedge clk); ifc.exp_we = 0;
    m_valid[i] = 1; m_kind[i] = k; m_addr[i] = a; m_data[i] = d;
  endtask

  task automatic sched_clr();
    for (int c = 0; c <= TO; c++) begin
      s_rwe[c] = 0; s_rad[c] = 0; s_rdt[c] = 0;
      s_mwe[c] = 0; s_mad[c] = 0; s_mdt[c] = 0;
    end
  endtask

  task automatic sw_reg(input int c, input int a, input logic [31:0] d);
    s_rwe[c] = 1; s_rad[c] = a; s_rdt[c] = d;
  endtask

  task automatic sw_mem(input int c, input int a, input logic [31:0] d);
    s_mwe[c] = 1; s_mad[c] = a; s_mdt[c] = d;
  endtask

  // reference: final value of each location after the window, then table walk
  function automatic exp_t model(input int stop_at);
    exp_t        e;
    int          rl;
    logic [31:0] rlast[int];
    logic [31:0] mlast[int];
    rl = (stop_at >= 1 && stop_at <= TO) ? stop_at : TO;
    for (int c = 1; c <= rl; c++) begin
      if (s_rwe[c] && s_rad[c] != 0) rlast[s_rad[c]] = s_rdt[c];
      if (s_mwe[c]) mlast[s_mad[c]] = s_mdt[c];
    end
    e.pass = 1; e.fidx = 0; e.fgot = 0; e.mcnt = 0; e.ccnt = rl; e.done_cyc = 0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        bit          seen;
        logic [31:0] g;
        int          key;
        if (!m_kind[i]) begin
          key  = m_addr[i] % 32;
          seen = rlast.exists(key);
          g    = seen ? rlast[key] : 32'd0;
        end else begin
          key  = m_addr[i];
          seen = mlast.exists(key);
          g    = seen ? mlast[key] : 32'd0;
        end
        if (seen && g == m_data[i]) e.mcnt++;
        else if (e.pass) begin e.pass = 0; e.fidx = i; e.fgot = g; end
      end
    end
    return e;
  endfunction

  // start a run, drive the schedule; junk adds ignored start/exp_* traffic
  task automatic do_run(input int stop_at, input bit junk);
    exp_t e;
    int   rl;
    e  = model(stop_at);
    rl = e.ccnt;
    @(negedge clk);
    ifc.start = 1;
    e.done_cyc = cyc + 1 + rl + N;
    sb.push_back(e);
    @(negedge clk);
    ifc.start = 0;
    chk("busy_after_start", ifc.busy, 1);
    chk("done_after_start", ifc.done, 0);
    for (int c = 1; c <= TO; c++) begin
      ifc.reg_we = s_rwe[c]; ifc.reg_waddr = RA'(s_rad[c]); ifc.reg_wdata = s_rdt[c];
      ifc.mem_we = s_mwe[c]; ifc.mem_addr = MA'(s_mad[c]); ifc.mem_wdata = s_mdt[c];
      ifc.stop = (c == stop_at);
      if (junk && c <= rl + N) begin
        ifc.start    = (c % 5 == 2);
        ifc.exp_we   = (c % 4 == 1);
        ifc.exp_clr  = (c % 7 == 3);
        ifc.exp_idx  = IW'($urandom_range(0, N - 1));
        ifc.exp_kind = 1'($urandom_range(0, 1));
        ifc.exp_addr = MA'($urandom_range(0, 7));
        ifc.exp_data = $urandom_range(0, 3);
      end else begin
        ifc.start = 0; ifc.exp_we = 0; ifc.exp_clr = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      ncmp++; nfail++;
      $display("FAIL done_timeout: done never rose, %0d verdicts pending", sb.size());
      sb.delete();
    end
  endtask

  // monitor: on each rising done, pop the expected verdict and compare
  initial begin
    logic dq;
    exp_t e;
    dq = 0;
    forever begin
      @(posedge clk); #1;
      if (ifc.done && !dq) begin
        if (sb.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL unexpected_done: done rose, expected no verdict");
        end else begin
          e = sb.pop_front();
          chk("pass",        ifc.pass,        e.pass);
          chk("fail_idx",    ifc.fail_idx,    e.fidx);
          chk("fail_got",    ifc.fail_got,    e.fgot);
          chk("match_count", ifc.match_count, e.mcnt);
          chk("cycle_count", ifc.cycle_count, e.ccnt);
          chk("done_cycle",  cyc,             e.done_cyc);
          chk("busy_at_done", ifc.busy,       0);
        end
      end
      dq = ifc.done;
    end
  end

  task automatic load_ref();
    tbl_clr();
    tbl_wr(0, 0, 8, 5);  tbl_wr(1, 0, 9, 10); tbl_wr(2, 0, 10, 5);
    tbl_wr(3, 0, 11, 1); tbl_wr(4, 0, 12, 20); tbl_wr(5, 0, 13, 5);
    tbl_wr(6, 1, 0, 5);
  endtask

  task automatic sched_ref();
    sched_clr();
    sw_reg(1, 8, 5); sw_reg(2, 9, 10); sw_reg(3, 10, 5); sw_reg(4, 11, 1);
    sw_reg(5, 12, 20); sw_reg(6, 13, 5); sw_mem(6, 0, 5);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"},  ifc.busy, 0);
    chk({pfx, "_done"},  ifc.done, 0);
    chk({pfx, "_pass"},  ifc.pass, 0);
    chk({pfx, "_fidx"},  ifc.fail_idx, 0);
    chk({pfx, "_fgot"},  ifc.fail_got, 0);
    chk({pfx, "_match"}, ifc.match_count, 0);
    chk({pfx, "_cyc"},   ifc.cycle_count, 0);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    sched_clr();
    #12;
    check_zero("reset");
    @(negedge clk); rst_n = 1;

    // reference program
    load_ref(); sched_ref(); do_run(0, 0);
    // mismatch on reg 12
    sched_ref(); sw_reg(5, 12, 19); do_run(0, 0);
    // last write wins, $zero never captured
    tbl_wr(7, 0, 0, 0);
    sched_ref(); sw_reg(10, 9, 3); sw_reg(11, 9, 10); sw_reg(12, 0, 7); do_run(0, 0);
    // early stop with simultaneous reg/mem writes; later writes ignored
    tbl_clr(); tbl_wr(0, 0, 8, 5); tbl_wr(6, 1, 0, 5);
    sched_clr(); sw_reg(4, 8, 5); sw_mem(4, 0, 5); sw_reg(5, 8, 9); sw_mem(6, 0, 9);
    do_run(4, 0);
    // missing write
    load_ref(); tbl_wr(3, 1, 5, 7); sched_ref(); do_run(0, 0);
    // empty table
    tbl_clr(); sched_clr(); do_run(0, 0);

    // async reset mid-run, away from any clock edge
    load_ref();
    @(negedge clk); ifc.start = 1;
    @(negedge clk); ifc.start = 0;
    repeat (3) @(negedge clk);
    chk("abort_pre_cyc", ifc.cycle_count, 3);
    #2 rst_n = 0;
    #1 check_zero("async_rst");
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    // table lost; exp_* traffic during the run must not leak in
    sched_clr(); do_run(0, 1);
    do_run(0, 0);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      tbl_clr();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          bit k;
          int a;
          k = 1'($urandom_range(0, 1));
          a = k ? $urandom_range(0, 7) : ($urandom_range(0, 7) | ($urandom_range(0, 7) << 5));
          tbl_wr(i, k, a, $urandom_range(0, 3));
        end
      end
      sched_clr();
      for (int c = 1; c <= TO; c++) begin
        if ($urandom_range(0, 1) != 0) sw_reg(c, $urandom_range(0, 7), $urandom_range(0, 3));
        if ($urandom_range(0, 1) != 0) sw_mem(c, $urandom_range(0, 7), $urandom_range(0, 3));
      end
      do_run($urandom_range(0, TO + 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
